// File: rtl/axil_sram_ctrl.sv
// axil_sram_ctrl: AXI4-Lite subordinate bridging single-beat reads/writes
// onto one registered single-port sram, one transaction in flight.
module axil_sram_ctrl #(
   parameter int MEM_AW = 8,
   parameter int DATA_W = 32,
   parameter int AXI_AW = MEM_AW + $clog2(DATA_W / 8)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AXI_AW-1:0]     s_awaddr,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [DATA_W-1:0]     s_wdata,
   input  logic [DATA_W/8-1:0]   s_wstrb,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [1:0]            s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [AXI_AW-1:0]     s_araddr,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [DATA_W-1:0]     s_rdata,
   output logic [1:0]            s_rresp,
   output logic                  s_rvalid,
   input  logic                  s_rready,
   output logic                  sram_cs,
   output logic                  sram_we,
   output logic [MEM_AW-1:0]     sram_addr,
   output logic [DATA_W-1:0]     sram_din,
   input  logic [DATA_W-1:0]     sram_dout
);

   localparam int BW = $clog2(DATA_W / 8);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR    = 3'd1,
      WRESP = 3'd2,
      RD    = 3'd3,
      RCAP  = 3'd4,
      RRESP = 3'd5
   } state_t;

   state_t              state_q;
   logic                wr_prio_q;
   logic                awready_q;
   logic                wready_q;
   logic                arready_q;
   logic                bvalid_q;
   logic [1:0]          bresp_q;
   logic                rvalid_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                cs_q;
   logic                we_q;
   logic [MEM_AW-1:0]   addr_q;
   logic [DATA_W-1:0]   din_q;
   logic                werr_q;

   logic wr_elig;
   logic rd_elig;
   logic both_elig;
   logic gnt_wr;
   logic gnt_rd;
   logic arb_en;

   // sub-word address bits carry no meaning for a word-wide sram
   logic unused_lsb;
   assign unused_lsb = ^{s_awaddr[BW-1:0], s_araddr[BW-1:0]};

   // pick the next transaction; ties go to wr_prio, arbitration runs
   // in idle and on the closing handshake so back-to-back ops lose no cycle
   always_comb begin
      wr_elig   = s_awvalid & s_wvalid;
      rd_elig   = s_arvalid;
      both_elig = wr_elig & rd_elig;
      gnt_wr    = wr_elig & (~rd_elig | wr_prio_q);
      gnt_rd    = rd_elig & (~wr_elig | ~wr_prio_q);
      arb_en    = ((state_q == IDLE) & ~awready_q & ~arready_q)
                | ((state_q == WRESP) & s_bready)
                | ((state_q == RRESP) & s_rready);
   end

   // transaction sequencer with registered AXI and sram outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_prio_q <= 1'b1;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         cs_q      <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         werr_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (awready_q) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  if (wr_elig) begin
                     werr_q  <= ~&s_wstrb;
                     cs_q    <= &s_wstrb;
                     we_q    <= &s_wstrb;
                     addr_q  <= s_awaddr[AXI_AW-1:BW];
                     din_q   <= s_wdata;
                     state_q <= WR;
                  end
               end else if (arready_q) begin
                  arready_q <= 1'b0;
                  if (rd_elig) begin
                     cs_q    <= 1'b1;
                     we_q    <= 1'b0;
                     addr_q  <= s_araddr[AXI_AW-1:BW];
                     state_q <= RD;
                  end
               end
            end
            WR: begin
               cs_q     <= 1'b0;
               we_q     <= 1'b0;
               bresp_q  <= werr_q ? 2'b10 : 2'b00;
               bvalid_q <= 1'b1;
               state_q  <= WRESP;
            end
            WRESP: begin
               if (s_bready) begin
                  bvalid_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            RD: begin
               cs_q    <= 1'b0;
               state_q <= RCAP;
            end
            RCAP: begin
               rdata_q  <= sram_dout;
               rvalid_q <= 1'b1;
               state_q  <= RRESP;
            end
            RRESP: begin
               if (s_rready) begin
                  rvalid_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         if (arb_en) begin
            awready_q <= gnt_wr;
            wready_q  <= gnt_wr;
            arready_q <= gnt_rd;
            if (both_elig) wr_prio_q <= ~wr_prio_q;
         end
      end
   end

   assign s_awready = awready_q;
   assign s_wready  = wready_q;
   assign s_arready = arready_q;
   assign s_bvalid  = bvalid_q;
   assign s_bresp   = bresp_q;
   assign s_rvalid  = rvalid_q;
   assign s_rdata   = rdata_q;
   assign s_rresp   = 2'b00;
   assign sram_cs   = cs_q;
   assign sram_we   = we_q;
   assign sram_addr = addr_q;
   assign sram_din  = din_q;

endmodule

// File: tb/tb_axil_sram_ctrl.sv
// tb_axil_sram_ctrl: directed and randomized AXI-Lite traffic against a
// word-array reference model, with a registered sram model attached.
module tb_axil_sram_ctrl;

   localparam int MEM_AW = 8;
   localparam int DATA_W = 32;
   localparam int AXI_AW = 10;

   logic               clk = 1'b0;
   logic               rst;
   logic [AXI_AW-1:0]  s_awaddr;
   logic               s_awvalid;
   logic               s_awready;
   logic [DATA_W-1:0]  s_wdata;
   logic [3:0]         s_wstrb;
   logic               s_wvalid;
   logic               s_wready;
   logic [1:0]         s_bresp;
   logic               s_bvalid;
   logic               s_bready;
   logic [AXI_AW-1:0]  s_araddr;
   logic               s_arvalid;
   logic               s_arready;
   logic [DATA_W-1:0]  s_rdata;
   logic [1:0]         s_rresp;
   logic               s_rvalid;
   logic               s_rready;
   logic               sram_cs;
   logic               sram_we;
   logic [MEM_AW-1:0]  sram_addr;
   logic [DATA_W-1:0]  sram_din;
   logic [DATA_W-1:0]  sram_dout;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] ref_mem [256];
   logic [31:0] mem [256];
   logic        mem_clr;
   int          cs_cnt = 0;
   int          rbeat_cnt = 0;
   int          bad_we = 0;

   always #5 clk = ~clk;

   axil_sram_ctrl #(.MEM_AW(MEM_AW), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
      .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
      .s_rready(s_rready),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout)
   );

   // registered sram: write on cs&we, read data the cycle after cs&~we
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (sram_cs) begin
         if (sram_we) mem[sram_addr] <= sram_din;
         else sram_dout <= mem[sram_addr];
      end
   end

   // event counters for sram pulses and R beats
   always @(posedge clk) begin
      if (sram_cs) cs_cnt <= cs_cnt + 1;
      if (s_rvalid && s_rready) rbeat_cnt <= rbeat_cnt + 1;
      if (sram_we && !sram_cs) bad_we <= bad_we + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // which: 0 = write side, 1 = read side, 2 = either
   task automatic wait_ready(input int which, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if ((which == 0 && s_awready) || (which == 1 && s_arready) ||
             (which == 2 && (s_awready || s_arready))) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk("ready_timeout", 64'(ok), 64'd1);
   endtask

   // entered in the cycle awready is high
   task automatic wr_finish(input logic [9:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int bdly,
                            input bit ar_during);
      bit full;
      int cs0;
      full = (s == 4'hF);
      cs0  = cs_cnt;
      chk("wready_pair", 64'(s_wready), 64'd1);
      step();
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      if (ar_during) s_arvalid = 1'b1;
      chk("wr_cs", 64'(sram_cs), 64'(full));
      chk("wr_we", 64'(sram_we), 64'(full));
      if (full) begin
         chk("wr_addr", 64'(sram_addr), 64'(a[9:2]));
         chk("wr_din", 64'(sram_din), 64'(d));
         ref_mem[a[9:2]] = d;
      end
      chk("bvalid_early", 64'(s_bvalid), 64'd0);
      step();
      chk("wr_cs_off", 64'(sram_cs), 64'd0);
      chk("bvalid", 64'(s_bvalid), 64'd1);
      chk("bresp", 64'(s_bresp), full ? 64'd0 : 64'd2);
      for (int i = 0; i < bdly; i++) begin
         step();
         chk("bvalid_hold", 64'(s_bvalid), 64'd1);
         chk("bresp_hold", 64'(s_bresp), full ? 64'd0 : 64'd2);
         chk("arready_busy", 64'(s_arready), 64'd0);
      end
      s_bready = 1'b1;
      step();
      s_bready = 1'b0;
      chk("bvalid_drop", 64'(s_bvalid), 64'd0);
      chk("cs_pulses", 64'(cs_cnt - cs0), full ? 64'd1 : 64'd0);
   endtask

   // entered in the cycle arready is high
   task automatic rd_finish(input logic [9:0] a, input logic [31:0] exp,
                            input int rdly);
      chk("awready_quiet", 64'(s_awready), 64'd0);
      step();
      s_arvalid = 1'b0;
      chk("rd_cs", 64'(sram_cs), 64'd1);
      chk("rd_we", 64'(sram_we), 64'd0);
      chk("rd_addr", 64'(sram_addr), 64'(a[9:2]));
      step();
      chk("rd_cs_off", 64'(sram_cs), 64'd0);
      chk("rvalid_early", 64'(s_rvalid), 64'd0);
      step();
      chk("rvalid", 64'(s_rvalid), 64'd1);
      chk("rdata", 64'(s_rdata), 64'(exp));
      chk("rresp", 64'(s_rresp), 64'd0);
      for (int i = 0; i < rdly; i++) begin
         step();
         chk("rvalid_hold", 64'(s_rvalid), 64'd1);
         chk("rdata_hold", 64'(s_rdata), 64'(exp));
         chk("awready_busy", 64'(s_awready), 64'd0);
      end
      s_rready = 1'b1;
      step();
      s_rready = 1'b0;
      chk("rvalid_drop", 64'(s_rvalid), 64'd0);
   endtask

   task automatic axi_write(input logic [9:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int bdly);
      bit ok;
      s_awaddr  = a;
      s_wdata   = d;
      s_wstrb   = s;
      s_awvalid = 1'b1;
      s_wvalid  = 1'b1;
      wait_ready(0, ok);
      if (ok) wr_finish(a, d, s, bdly, 1'b0);
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
   endtask

   task automatic axi_read(input logic [9:0] a, input int rdly);
      bit ok;
      s_araddr  = a;
      s_arvalid = 1'b1;
      wait_ready(1, ok);
      if (ok) rd_finish(a, ref_mem[a[9:2]], rdly);
      s_arvalid = 1'b0;
   endtask

   initial begin
      bit          ok;
      int          tms [3];
      int          n;
      int          r0;
      logic [9:0]  a;
      logic [31:0] d;
      logic [3:0]  s;

      rst = 1'b1;
      mem_clr = 1'b1;
      s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
      s_wvalid = 1'b0; s_bready = 1'b0; s_araddr = '0;
      s_arvalid = 1'b0; s_rready = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      repeat (3) step();
      rst = 1'b0;
      mem_clr = 1'b0;

      chk("rst_ready", 64'({s_awready, s_wready, s_arready}), 64'd0);
      chk("rst_valid", 64'({s_bvalid, s_rvalid}), 64'd0);
      chk("rst_resp", 64'({s_bresp, s_rresp}), 64'd0);
      chk("rst_rdata", 64'(s_rdata), 64'd0);
      chk("rst_sram", 64'({sram_cs, sram_we, sram_addr}), 64'd0);
      chk("rst_din", 64'(sram_din), 64'd0);

      // both sides valid from reset: write wins, then read, then read wins
      s_awaddr = 10'h020; s_wdata = 32'hA5A5_0001; s_wstrb = 4'hF;
      s_araddr = 10'h024;
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
      wait_ready(2, ok);
      chk("prio_wr_first", 64'(s_awready), 64'd1);
      chk("prio_ar_held", 64'(s_arready), 64'd0);
      if (ok) wr_finish(10'h020, 32'hA5A5_0001, 4'hF, 0, 1'b0);
      chk("ar_next", 64'(s_arready), 64'd1);
      if (s_arready) rd_finish(10'h024, ref_mem[9], 0);
      s_arvalid = 1'b0;
      s_awaddr = 10'h030; s_wdata = 32'h5A5A_0002; s_wstrb = 4'hF;
      s_araddr = 10'h020;
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
      wait_ready(2, ok);
      chk("prio_rd_first", 64'(s_arready), 64'd1);
      if (ok && s_arready) rd_finish(10'h020, ref_mem[8], 0);
      chk("aw_next", 64'(s_awready), 64'd1);
      if (s_awready) wr_finish(10'h030, 32'h5A5A_0002, 4'hF, 0, 1'b0);
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;

      // full write and readback at 0x14
      axi_write(10'h014, 32'hDEAD_BEEF, 4'hF, 0);
      axi_read(10'h014, 0);

      // partial strobe is refused and leaves memory untouched
      axi_write(10'h008, 32'h1111_1111, 4'hF, 0);
      axi_write(10'h008, 32'hAAAA_AAAA, 4'h3, 0);
      axi_read(10'h008, 0);
      chk("partial_kept", 64'(ref_mem[2]), 64'h1111_1111);

      // AW without W is never taken alone
      s_awaddr = 10'h044; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("aw_alone", 64'({s_awready, s_wready}), 64'd0);
      end
      s_wvalid = 1'b1;
      wait_ready(0, ok);
      if (ok) wr_finish(10'h044, 32'h0BAD_F00D, 4'hF, 0, 1'b0);
      s_awvalid = 1'b0; s_wvalid = 1'b0;

      // B stall blocks a pending read until the B handshake
      s_araddr = 10'h014;
      s_awaddr = 10'h050; s_wdata = 32'h1234_5678; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      wait_ready(0, ok);
      if (ok) wr_finish(10'h050, 32'h1234_5678, 4'hF, 5, 1'b1);
      chk("ar_after_b", 64'(s_arready), 64'd1);
      if (s_arready) rd_finish(10'h014, ref_mem[5], 0);
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;

      // write throughput with bready held high
      s_awaddr = 10'h060; s_wdata = 32'hCAFE_0003; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
      n = 0;
      for (int c = 0; c < 40 && n < 3; c++) begin
         step();
         if (s_awready) begin tms[n] = c; n++; end
      end
      step();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      repeat (4) step();
      s_bready = 1'b0;
      ref_mem[8'h18] = 32'hCAFE_0003;
      chk("wr_tput_n", 64'(n), 64'd3);
      chk("wr_tput_gap1", 64'(tms[1] - tms[0]), 64'd3);
      chk("wr_tput_gap2", 64'(tms[2] - tms[1]), 64'd3);

      // read throughput with rready held high
      s_araddr = 10'h060; s_arvalid = 1'b1; s_rready = 1'b1;
      n = 0;
      for (int c = 0; c < 40 && n < 3; c++) begin
         step();
         if (s_arready) begin tms[n] = c; n++; end
      end
      step();
      s_arvalid = 1'b0;
      repeat (5) step();
      s_rready = 1'b0;
      chk("rd_tput_n", 64'(n), 64'd3);
      chk("rd_tput_gap1", 64'(tms[1] - tms[0]), 64'd4);
      chk("rd_tput_gap2", 64'(tms[2] - tms[1]), 64'd4);

      // reset during RCAP drops the read without an R beat
      s_araddr = 10'h014; s_arvalid = 1'b1;
      wait_ready(1, ok);
      step();
      s_arvalid = 1'b0;
      step();
      rst = 1'b1;
      s_rready = 1'b1;
      r0 = rbeat_cnt;
      step();
      rst = 1'b0;
      chk("rst_rcap_rvalid", 64'(s_rvalid), 64'd0);
      chk("rst_rcap_cs", 64'(sram_cs), 64'd0);
      chk("rst_rcap_arready", 64'(s_arready), 64'd0);
      repeat (6) step();
      chk("rst_rcap_no_r", 64'(rbeat_cnt - r0), 64'd0);
      s_rready = 1'b0;
      axi_read(10'h014, 0);

      // random traffic against the word-array model
      for (int it = 0; it < 60; it++) begin
         a = {8'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14))
                                            : 4'hF;
            axi_write(a, d, s, int'($urandom_range(0, 3)));
         end else begin
            axi_read(a, int'($urandom_range(0, 3)));
         end
      end

      chk("we_without_cs", 64'(bad_we), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
